// File: rtl/pc_unit_ras.sv
// Program-counter unit with a four-source next-PC select, a circular
// return-address stack for call/return, and sticky error flags.
module pc_unit_ras #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter int               STEP       = 4,
  parameter int               ALIGN_BITS = 2,
  parameter int               RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   sel,
  input  logic [WIDTH-1:0]             alu_din,
  input  logic [WIDTH-1:0]             reg_din,
  input  logic [WIDTH-1:0]             im_din,
  input  logic                         call,
  input  logic                         ret,
  output logic [WIDTH-1:0]             pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty,
  output logic                         ovf_err,
  output logic                         unf_err,
  output logic                         align_err
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] AMASK = {WIDTH{1'b1}} << ALIGN_BITS;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d;    // next free slot; top entry sits at top_q-1
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, aln_q, aln_d;

  logic [WIDTH-1:0] seq_pc, tgt, sel_pc;
  logic [PW-1:0]    top_m1;
  logic             empty, full;

  always_comb begin
    seq_pc = pc_q + WIDTH'(STEP);
    unique case (sel)
      2'b01:   tgt = alu_din;
      2'b10:   tgt = reg_din;
      2'b11:   tgt = im_din;
      default: tgt = seq_pc;
    endcase
    sel_pc = (sel == 2'b00) ? seq_pc : (tgt & AMASK);
    top_m1 = top_q - 1'b1;
    empty  = (count_q == '0);
    full   = (count_q == CW'(RAS_DEPTH));

    pc_d    = pc_q;
    ras_d   = ras_q;
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    aln_d   = aln_q;

    if (en) begin
      if (ret && !empty) begin
        // Pop, or swap when call is also set: top is replaced in place.
        pc_d = ras_q[top_m1];
        if (call) begin
          ras_d[top_m1] = seq_pc;
        end else begin
          top_d   = top_m1;
          count_d = count_q - 1'b1;
        end
      end else begin
        if (ret) unf_d = 1'b1;
        if (ret && !call) begin
          pc_d = seq_pc;
        end else begin
          pc_d = sel_pc;
          if (sel != 2'b00 && (tgt & ~AMASK) != '0) aln_d = 1'b1;
          if (call) begin
            // When full, top_q points at the oldest entry, so this overwrites it.
            ras_d[top_q] = seq_pc;
            top_d        = top_q + 1'b1;
            if (full) ovf_d   = 1'b1;
            else      count_d = count_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      ras_q   <= '{default: '0};
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      aln_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ras_q   <= ras_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      aln_q   <= aln_d;
    end
  end

  assign pc        = pc_q;
  assign ras_count = count_q;
  assign ras_full  = full;
  assign ras_empty = empty;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;
  assign align_err = aln_q;
endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: directed scenarios then random traffic,
// checked against a queue-based stack model.
module tb_pc_unit_ras;
  logic        clk = 1'b0;
  logic        rst, en, call, ret;
  logic [1:0]  sel;
  logic [31:0] alu_din, reg_din, im_din, pc;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ovf_err, unf_err, align_err;

  pc_unit_ras dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .alu_din(alu_din), .reg_din(reg_din), .im_din(im_din),
    .call(call), .ret(ret), .pc(pc), .ras_count(ras_count),
    .ras_full(ras_full), .ras_empty(ras_empty),
    .ovf_err(ovf_err), .unf_err(unf_err), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          cnt;
    bit          ovf, unf, aln;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;

  // Reference model: the stack is a plain queue, newest at the back.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_stk[$];
  bit          m_ovf = 0, m_unf = 0, m_aln = 0;

  task automatic model_step(input bit r, e, input logic [1:0] s,
                            input logic [31:0] a, g, i, input bit c, t);
    logic [31:0] seq, tg, top;
    if (r) begin
      m_pc = 32'h0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_aln = 0;
    end else if (e) begin
      seq = m_pc + 32'd4;
      tg  = (s == 2'd1) ? a : (s == 2'd2) ? g : i;
      if (t && m_stk.size() > 0) begin
        top = m_stk.pop_back();
        if (c) m_stk.push_back(seq);
        m_pc = top;
      end else begin
        if (t) m_unf = 1;
        if (t && !c) m_pc = seq;
        else begin
          if (s == 2'd0) m_pc = seq;
          else begin
            if (tg % 4 != 0) m_aln = 1;
            m_pc = tg - (tg % 4);
          end
          if (c) begin
            if (m_stk.size() == 4) begin
              void'(m_stk.pop_front());
              m_ovf = 1;
            end
            m_stk.push_back(seq);
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit r, e, input logic [1:0] s,
                     input logic [31:0] a, g, i, input bit c, t);
    exp_t x;
    rst = r; en = e; sel = s; alu_din = a; reg_din = g; im_din = i; call = c; ret = t;
    model_step(r, e, s, a, g, i, c, t);
    @(posedge clk);
    x.pc = m_pc; x.cnt = m_stk.size(); x.ovf = m_ovf; x.unf = m_unf; x.aln = m_aln;
    exp_q.push_back(x);
    #1;
  endtask

  task automatic jmp(input logic [31:0] tgt, input bit c = 0);
    cyc(0, 1, 2'd3, 32'h0, 32'h0, tgt, c, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc",        pc,                 e.pc);
      chk("ras_count", 32'(ras_count),     32'(e.cnt));
      chk("ras_full",  32'(ras_full),      32'(e.cnt == 4));
      chk("ras_empty", 32'(ras_empty),     32'(e.cnt == 0));
      chk("ovf_err",   32'(ovf_err),       32'(e.ovf));
      chk("unf_err",   32'(unf_err),       32'(e.unf));
      chk("align_err", 32'(align_err),     32'(e.aln));
    end
  end

  initial begin
    // Reset, sequential fetch, hold.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 2'd3, 0, 0, 32'h400, 1, 1);
    // Source mux and alignment.
    cyc(0, 1, 2'd1, 32'h100, 0, 0, 0, 0);
    cyc(0, 1, 2'd2, 0, 32'h200, 0, 0, 0);
    cyc(0, 1, 2'd3, 0, 0, 32'h302, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    // Call/return nesting.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    jmp(32'h10);
    jmp(32'h80, 1);
    jmp(32'hC0, 1);
    repeat (2) cyc(0, 1, 0, 0, 0, 0, 0, 1);
    // Overflow then LIFO recovery of the newest four.
    jmp(32'h00);
    for (int k = 1; k <= 5; k++) jmp(32'(k * 16), 1);
    repeat (4) cyc(0, 1, 2'd1, 32'h777, 0, 0, 0, 1);
    // Underflow and swap.
    jmp(32'h50);
    cyc(0, 1, 2'd3, 0, 0, 32'h900, 0, 1);
    jmp(32'h1FC);
    jmp(32'h60, 1);
    cyc(0, 1, 2'd3, 0, 0, 32'h900, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    // Wrap and reset during a call with a partly filled stack.
    jmp(32'hFFFF_FFFC);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) jmp(32'h40, 1);
    cyc(1, 1, 2'd3, 0, 0, 32'h80, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, g, i;
      a = $urandom; g = $urandom; i = $urandom;
      if ($urandom_range(0, 1) == 0) begin a[1:0] = 0; g[1:0] = 0; i[1:0] = 0; end
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
          2'($urandom_range(0, 3)), a, g, i,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
